// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the execute stage: opcode encodings, the control
// state enumeration and bit positions inside the packed status-flag vector.
// -----------------------------------------------------------------------------
package exec_pkg;

  // Opcode encodings (4-bit opcode field). Values 0xB..0xF pass A through.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_INC = 4'h1;
  localparam logic [3:0] OP_DEC = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;

  // Control state: single-cycle operation or multiply in progress.
  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  // Bit positions inside the packed flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_W = 3;

endpackage

// File: rtl/exec_mul_seq.sv
// -----------------------------------------------------------------------------
// exec_mul_seq
// Sequential shift-add multiplier, one bit of the multiplier per cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (aborts any multiply)
//   start    pulse: latch a/b and begin a DATA_W-cycle multiply
//   a, b     DATA_W-bit unsigned operands
//   busy     multiply in progress
//   done     high during the final iteration cycle; product is valid then
//   product  2*DATA_W-bit product, valid while done is high
//
// done and product are combinational on the final iteration so the caller can
// register the result on the same edge that retires the last bit.
// -----------------------------------------------------------------------------
module exec_mul_seq #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] mcand_reg;
  logic [2*DATA_W-1:0] acc_reg;
  logic [2*DATA_W-1:0] acc_next;
  logic [DATA_W-1:0]   mplier_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                busy_reg;

  // Add the shifted multiplicand when the current multiplier LSB is set.
  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign done     = busy_reg && (cnt_reg == CNT_W'(DATA_W - 1));
  assign busy     = busy_reg;
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= {{DATA_W{1'b0}}, a};
      mplier_reg <= b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      if (done) begin
        busy_reg <= 1'b0;
        cnt_reg  <= '0;
      end else begin
        cnt_reg  <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/execute_unit.sv
// -----------------------------------------------------------------------------
// execute_unit
// Parametrised execute stage between decode and register-file writeback.
// Single-cycle ALU ops retire one cycle after acceptance; MUL runs on a
// sequential shift-add multiplier and retires DATA_W cycles after acceptance.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake (transfer when both high)
//   opcode               operation select (see exec_pkg)
//   operand              destination register address
//   data_a, data_b       source operands
//   out_valid/out_ready  writeback handshake (transfer when both high)
//   result, write_addr   registered result and destination address
//   flag_z/flag_c/flag_v zero, carry/borrow/clamp/mul-overflow, signed overflow
// -----------------------------------------------------------------------------
module execute_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter bit SAT_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] operand,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] write_addr,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  state_t state_reg, state_next;

  logic                  accept;
  logic                  is_mul;
  logic                  mul_start;
  logic                  mul_busy;
  logic                  mul_done;
  logic [2*DATA_W-1:0]   mul_product;
  logic [FLAG_W-1:0]     mul_flags;
  logic [ADDR_W-1:0]     mul_addr_reg;

  logic [DATA_W-1:0]     alu_res;
  logic [FLAG_W-1:0]     alu_flags;
  logic [DATA_W:0]       arith_ext;
  logic [DATA_W-1:0]     arith_b;
  logic                  arith_sub;

  logic                  out_valid_reg;
  logic [DATA_W-1:0]     result_reg;
  logic [ADDR_W-1:0]     write_addr_reg;
  logic [FLAG_W-1:0]     flags_reg;

  // A new instruction is taken only when idle and the output slot is free
  // or being drained on this same edge.
  assign in_ready = (state_reg == IDLE) && !mul_busy && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (opcode == OP_MUL);

  // ---------------------------------------------------------------------------
  // Combinational ALU (everything except MUL)
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_res   = data_a;
    alu_flags = '0;
    arith_sub = (opcode == OP_SUB) || (opcode == OP_DEC);
    arith_b   = ((opcode == OP_INC) || (opcode == OP_DEC)) ? DATA_W'(1) : data_b;
    // One extra bit captures carry-out on add and borrow on subtract.
    arith_ext = arith_sub ? ({1'b0, data_a} - {1'b0, arith_b})
                          : ({1'b0, data_a} + {1'b0, arith_b});
    case (opcode)
      OP_INC, OP_DEC, OP_ADD, OP_SUB: begin
        alu_res           = arith_ext[DATA_W-1:0];
        alu_flags[FLAG_C] = arith_ext[DATA_W];
        // Signed overflow uses the unclamped result: add overflows when the
        // operands agree in sign, subtract when they differ, and the result
        // sign then disagrees with A.
        alu_flags[FLAG_V] = (arith_sub ? (data_a[MSB] != arith_b[MSB])
                                       : (data_a[MSB] == arith_b[MSB]))
                            && (arith_ext[MSB] != data_a[MSB]);
        if (SAT_EN && arith_ext[DATA_W]) begin
          alu_res = arith_sub ? '0 : '1;
        end
      end
      OP_AND:  alu_res = data_a & data_b;
      OP_OR:   alu_res = data_a | data_b;
      OP_XOR:  alu_res = data_a ^ data_b;
      OP_SHL:  alu_res = data_a << data_b[SH_W-1:0];
      OP_SHR:  alu_res = data_a >> data_b[SH_W-1:0];
      default: alu_res = data_a;
    endcase
    alu_flags[FLAG_Z] = (alu_res == '0);
  end

  // ---------------------------------------------------------------------------
  // Multiplier
  // ---------------------------------------------------------------------------
  exec_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (data_a),
    .b       (data_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_product[DATA_W-1:0] == '0);
    mul_flags[FLAG_C] = |mul_product[2*DATA_W-1:DATA_W];
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    mul_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && is_mul) begin
          state_next = MUL_BUSY;
          mul_start  = 1'b1;
        end
      end
      MUL_BUSY: begin
        if (mul_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      out_valid_reg  <= 1'b0;
      result_reg     <= '0;
      write_addr_reg <= '0;
      flags_reg      <= '0;
      mul_addr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        if (is_mul) begin
          // Any previous result drained on this edge (accept implies it).
          mul_addr_reg  <= operand;
          out_valid_reg <= 1'b0;
        end else begin
          result_reg     <= alu_res;
          write_addr_reg <= operand;
          flags_reg      <= alu_flags;
          out_valid_reg  <= 1'b1;
        end
      end else if (mul_done) begin
        result_reg     <= mul_product[DATA_W-1:0];
        write_addr_reg <= mul_addr_reg;
        flags_reg      <= mul_flags;
        out_valid_reg  <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign result     = result_reg;
  assign write_addr = write_addr_reg;
  assign flag_z     = flags_reg[FLAG_Z];
  assign flag_c     = flags_reg[FLAG_C];
  assign flag_v     = flags_reg[FLAG_V];

endmodule
